// File: rtl/fust_g_issue.sv
// FUST-G reader: holds one dispatched op, wakes its operands from the writeback bus,
// issues it to the G FU and returns a busy-clear. Optional same-cycle wakeup: FUST_G_BYPASS_EN.
module fust_g_issue #(
    parameter int OP_W    = 5,
    parameter int TAG_W   = 3,
    parameter int STALL_W = 8
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               fust_new,
    input  logic [OP_W-1:0]    fust_op,
    input  logic               fust_t1_pend,
    input  logic [TAG_W-1:0]   fust_t1_tag,
    input  logic               fust_t2_pend,
    input  logic [TAG_W-1:0]   fust_t2_tag,
    input  logic               wb_valid,
    input  logic [TAG_W-1:0]   wb_tag,
    input  logic               flush,
    input  logic               fu_ready,
    input  logic               fu_done,
    output logic               fu_valid,
    output logic [OP_W-1:0]    fu_op,
    output logic               busy_clr,
    output logic [STALL_W-1:0] stall_cycles,
    output logic               dispatch_err,
    output logic [2:0]         dbg_state
);

    // FU handshake: an op is handed off on a rising edge where fu_valid && fu_ready;
    // fu_valid never depends on fu_ready, and a flush gates fu_valid in the same cycle.
    typedef enum logic [2:0] {IDLE, WAIT, ISSUE, EXEC, CLEAR} state_t;

    state_t             state;
    logic [OP_W-1:0]    op_q;
    logic               t1_pend_q, t2_pend_q;
    logic [TAG_W-1:0]   t1_tag_q, t2_tag_q;
    logic [STALL_W-1:0] stall_q;
    logic               busy_clr_q, err_q;

    logic new1, new2, w1, w2, opnd_rdy, new_rdy, stall_max;

    always_comb begin
        new1      = fust_t1_pend && !(wb_valid && (wb_tag == fust_t1_tag));
        new2      = fust_t2_pend && !(wb_valid && (wb_tag == fust_t2_tag));
        w1        = t1_pend_q && !(wb_valid && (wb_tag == t1_tag_q));
        w2        = t2_pend_q && !(wb_valid && (wb_tag == t2_tag_q));
        stall_max = &stall_q;
`ifdef FUST_G_BYPASS_EN
        opnd_rdy  = !w1 && !w2;
        new_rdy   = !new1 && !new2;
`else
        opnd_rdy  = !t1_pend_q && !t2_pend_q;
        new_rdy   = 1'b0;
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            op_q       <= '0;
            t1_pend_q  <= 1'b0;
            t2_pend_q  <= 1'b0;
            t1_tag_q   <= '0;
            t2_tag_q   <= '0;
            stall_q    <= '0;
            busy_clr_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            busy_clr_q <= 1'b0;
            if (fust_new && (state != IDLE))
                err_q <= 1'b1;
            case (state)
                IDLE: begin
                    // Capture wins over a coincident flush.
                    if (fust_new) begin
                        op_q      <= fust_op;
                        t1_pend_q <= new1;
                        t2_pend_q <= new2;
                        t1_tag_q  <= fust_t1_tag;
                        t2_tag_q  <= fust_t2_tag;
                        stall_q   <= '0;
                        state     <= new_rdy ? ISSUE : WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state      <= IDLE;
                        busy_clr_q <= 1'b1;
                    end else begin
                        t1_pend_q <= w1;
                        t2_pend_q <= w2;
                        if (opnd_rdy)
                            state <= ISSUE;
                        else if (!stall_max)
                            stall_q <= stall_q + 1'b1;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state      <= IDLE;
                        busy_clr_q <= 1'b1;
                    end else if (fu_ready) begin
                        state <= EXEC;
                    end else if (!stall_max) begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                EXEC: begin
                    if (flush || fu_done) begin
                        state      <= flush ? IDLE : CLEAR;
                        busy_clr_q <= 1'b1;
                    end
                end
                CLEAR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign fu_valid     = (state == ISSUE) && !flush;
    assign fu_op        = op_q;
    assign busy_clr     = busy_clr_q;
    assign stall_cycles = stall_q;
    assign dispatch_err = err_q;
    assign dbg_state    = state;

endmodule
